// File: rtl/hwag_pkg.sv
// Shared definitions for the crank/cam wheel emulator: wheel defaults, FSM state, period clamp.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package hwag_pkg;

  // 60-2 wheel defaults
  localparam int HWAG_TOOTH_COUNT = 60;
  localparam int HWAG_MISSING     = 2;
  localparam int HWAG_PERIOD_MIN  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } emu_state_t;

  // Floors a requested slot length. A 32-bit carrier is used, so callers
  // with PERIOD_W wider than 32 would lose their upper bits.
  function automatic logic [31:0] clamp_period(input logic [31:0] p,
                                               input logic [31:0] p_min);
    return (p < p_min) ? p_min : p;
  endfunction

endpackage

// File: rtl/crank_slot_timer.sv
// Slot tick counter with per-slot period latch; flags last tick and the tick before the half point.
// Latency: flags are combinational from registered tick/period; a load takes effect next cycle.
// Backpressure: none; i_load/i_run are obeyed every cycle.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_load          start a new slot next cycle: tick=0, period=clamp(i_tooth_period)
//   i_run           advance the tick counter (ignored when i_load is high)
//   i_tooth_period  requested slot length in clk ticks
//   o_last          current tick is the final tick of the slot (tick == P-1)
//   o_pre_half      next tick is the half point (tick+1 == P>>1)
module crank_slot_timer
  import hwag_pkg::*;
#(
  parameter int PERIOD_W   = 24,
  parameter int PERIOD_MIN = HWAG_PERIOD_MIN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic                i_run,
  input  logic [PERIOD_W-1:0] i_tooth_period,
  output logic                o_last,
  output logic                o_pre_half
);

  logic [PERIOD_W-1:0] r_tick;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] w_period_clamped;

  assign w_period_clamped = PERIOD_W'(clamp_period(32'(i_tooth_period), 32'(PERIOD_MIN)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick   <= '0;
      r_period <= '0;
    end else if (i_load) begin
      r_tick   <= '0;
      r_period <= w_period_clamped;
    end else if (i_run) begin
      r_tick <= r_tick + PERIOD_W'(1);
    end else begin
      r_tick <= '0;
    end
  end

  // The period is never below PERIOD_MIN once loaded, so P-1 cannot underflow
  // and the counter stops at P-1 because o_last forces a reload or an exit.
  assign o_last = (r_tick == r_period - PERIOD_W'(1));

  // Flagged one tick early so the registered cap output drops exactly on tick P>>1.
  assign o_pre_half = ((r_tick + PERIOD_W'(1)) == (r_period >> 1));

endmodule

// File: rtl/crank_cam_emulator.sv
// Synthetic 60-2 crank and cam signal generator with run-time tooth period.
// Latency: enable seen at a boundary (or in IDLE) acts on the next cycle; all outputs registered.
// Backpressure: none; enable drops are deferred to the end of the current slot.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   enable        run request, honoured only at slot boundaries while running
//   tooth_period  slot length in clk ticks, latched at each slot start
//   cap           crank tooth signal, falling edge marks the tooth
//   cam           high for slots CAM_START..CAM_END in revolution CAM_PHASE
//   tooth_num     current slot index 0..TOOTH_COUNT-1 (0 when idle)
//   rev_phase     revolution parity within the 720-degree cycle
//   slot_strobe   one-cycle pulse on the first cycle of every slot
//   running       high while in RUN
module crank_cam_emulator
  import hwag_pkg::*;
#(
  parameter int PERIOD_W    = 24,
  parameter int TOOTH_COUNT = HWAG_TOOTH_COUNT,
  parameter int MISSING     = HWAG_MISSING,
  parameter int CAM_PHASE   = 0,
  parameter int CAM_START   = 0,
  parameter int CAM_END     = 29,
  parameter int PERIOD_MIN  = HWAG_PERIOD_MIN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] tooth_period,
  output logic                cap,
  output logic                cam,
  output logic [7:0]          tooth_num,
  output logic                rev_phase,
  output logic                slot_strobe,
  output logic                running
);

  emu_state_t r_state;
  emu_state_t w_state_next;
  logic       w_load;
  logic       w_last;
  logic       w_pre_half;
  logic [7:0] w_tooth_next;
  logic       w_phase_next;
  logic       w_wrap;
  logic       w_cap_next;
  logic       w_cam_next;

  crank_slot_timer #(
    .PERIOD_W   (PERIOD_W),
    .PERIOD_MIN (PERIOD_MIN)
  ) u_slot_timer (
    .clk            (clk),
    .rst            (rst),
    .i_load         (w_load),
    .i_run          (r_state == RUN),
    .i_tooth_period (tooth_period),
    .o_last         (w_last),
    .o_pre_half     (w_pre_half)
  );

  assign w_wrap = (tooth_num == 8'(TOOTH_COUNT - 1));

  // Next state and the slot that would start on the next cycle.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_tooth_next = 8'd0;
    w_phase_next = rev_phase;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_next = RUN;
          w_load       = 1'b1;
        end
      end
      RUN: begin
        if (w_last) begin
          if (enable) begin
            w_load = 1'b1;
            if (w_wrap) begin
              w_tooth_next = 8'd0;
              w_phase_next = ~rev_phase;
            end else begin
              w_tooth_next = tooth_num + 8'd1;
            end
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Per-slot decode of the slot about to start; int casts keep the
  // range checks well-formed whatever the window parameters are.
  assign w_cap_next = (int'(w_tooth_next) < (TOOTH_COUNT - MISSING));
  assign w_cam_next = (w_phase_next == 1'(CAM_PHASE)) &&
                      (int'(w_tooth_next) >= CAM_START) &&
                      (int'(w_tooth_next) <= CAM_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      cap         <= 1'b0;
      cam         <= 1'b0;
      tooth_num   <= 8'd0;
      rev_phase   <= 1'b0;
      slot_strobe <= 1'b0;
      running     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      slot_strobe <= w_load;
      if (w_load) begin
        running   <= 1'b1;
        tooth_num <= w_tooth_next;
        rev_phase <= w_phase_next;
        cap       <= w_cap_next;
        cam       <= w_cam_next;
      end else if (w_state_next == IDLE) begin
        // rev_phase is deliberately held so a restart keeps cycle parity.
        running   <= 1'b0;
        tooth_num <= 8'd0;
        cap       <= 1'b0;
        cam       <= 1'b0;
      end else if (w_pre_half) begin
        cap <= 1'b0;
      end
    end
  end

endmodule

// File: doc/crank_cam_emulator.md
Name: crank_cam_emulator

Overview:
- Generates synthetic crankshaft (60-2 tooth wheel) and camshaft signals: the transmitter counterpart to the angle generator's crank/cam decoder.
- Drives the decoder's cap/cam inputs in loopback benches and on the bench board.
- Tooth timing is programmable at run time in clk ticks; the cam window is positioned by parameters over a 720-degree (two-revolution) cycle.

Parameters:
- PERIOD_W, 24, width of tooth_period and of the internal slot tick counter.
- TOOTH_COUNT, 60, slots per revolution, including missing teeth.
- MISSING, 2, missing slots at the end of each revolution (slots TOOTH_COUNT-MISSING..TOOTH_COUNT-1).
- CAM_PHASE, 0, rev_phase value during which the cam window is active.
- CAM_START, 0, first slot index with cam high (inclusive).
- CAM_END, 29, last slot index with cam high (inclusive).
- PERIOD_MIN, 4, floor applied to tooth_period.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- enable, input, 1, run request, sampled at slot boundaries.
- tooth_period, input, PERIOD_W, slot length in clk ticks; latched at each slot start.
- cap, output, 1, crank tooth signal; the falling edge is the tooth edge.
- cam, output, 1, cam signal.
- tooth_num, output, 8, current slot index, 0..TOOTH_COUNT-1.
- rev_phase, output, 1, revolution parity within the 720-degree cycle.
- slot_strobe, output, 1, one-cycle pulse on the first cycle of every slot.
- running, output, 1, high while in RUN.

Behaviour:
- Reset (asynchronous): state=IDLE; cap, cam, tooth_num, rev_phase, slot_strobe, running, tick counter and latched period all 0.
- States are IDLE and RUN.
- IDLE -> RUN: enable=1 sampled at cycle n. In cycle n+1:
  - running=1, slot_strobe=1, tooth_num=0, rev_phase unchanged, tick=0, cap=1.
  - Latched period P = max(tooth_period, PERIOD_MIN).
- Slot timing: tick counts 0..P-1, so a slot lasts exactly P cycles.
  - Normal slot: cap=1 while tick < P>>1, and cap=0 from tick == P>>1.
  - Missing slot: cap=0 for the whole slot.
- Slot boundary: the cycle where tick==P-1. On the next cycle:
  - tick=0, slot_strobe=1, new P latched.
  - tooth_num increments; at TOOTH_COUNT-1 it wraps to 0 and rev_phase toggles.
- All outputs are registered and change together on the slot's first cycle. cap and cam must never glitch.
- cam=1 iff running, rev_phase==CAM_PHASE, and CAM_START <= tooth_num <= CAM_END. It is evaluated per slot.
- enable=0 is honoured only at a slot boundary:
  - The next cycle is IDLE; cap, cam, slot_strobe, running and tooth_num all go to 0.
  - rev_phase is held.
  - A partial slot is never truncated.
- Simultaneous events at a boundary:
  - enable drop together with a period change: the drop wins and the period is ignored.
  - enable high together with a period change: the new period applies to the new slot only.
- tooth_period changes mid-slot have no effect until the next slot start.
- Period clamp: values below PERIOD_MIN use PERIOD_MIN; 0 is legal input and yields PERIOD_MIN.
- Arithmetic: P>>1 uses truncation. Odd P gives a high phase of floor(P/2) cycles and a low phase of ceil(P/2) cycles.
- The tick counter never wraps past P-1. The full PERIOD_W range is legal.
- Reset mid-operation: immediate return to reset values; no completion of the current slot.

Decomposition:
- Shared package hwag_pkg holds:
  - the TOOTH_COUNT, MISSING and PERIOD_MIN defaults;
  - the emu_state_t enum (IDLE, RUN);
  - the period clamp function.
- One sub-module, crank_slot_timer. It holds the tick counter and period latch, and outputs the boundary and half-point flags. The top holds the FSM, tooth/phase counters and cam decode.

Test Plan:
- Reset, then enable=1 with tooth_period=1000 -> one cycle later: running=1, cap=1, tooth_num=0; cap falls 500 cycles after the slot start.
- Full revolution at P=1000:
  - 58 cap falling edges spaced 1000 cycles apart.
  - Gap of 3000 cycles between the tooth-57 fall and the next tooth-0 fall.
  - rev_phase toggles once, and slot_strobe fires 60 times.
- Cam window over two revolutions, P=600 -> cam high for exactly 30 slots (18000 cycles) in phase 0 only, rising on the tooth-0 slot start.
- tooth_period changed from 1000 to 2000 at tick 300 of slot 5 -> slot 5 lasts 1000 cycles; slot 6 lasts 2000 cycles with its fall at tick 1000.
- enable dropped at tick 10 of slot 20 -> outputs hold until the slot ends, then go to 0; rev_phase is held; re-enable restarts at tooth_num=0.
- tooth_period=1 and 0 -> slot length 4 with 2 high cycles; rst asserted mid-slot -> all outputs 0 in the same cycle.
- Loopback with the angle generator at P=1000 -> its start indication asserts after gap detection.
